// File: rtl/uart_receiver.sv
// 16x-oversampled 8N1 UART receiver with framing-error detection.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int SAMPLE_WIDTH = 9,
    parameter int SAMPLE_LIMIT = 326,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_error
`endif
);

    localparam int N_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [SAMPLE_WIDTH-1:0] PRESC_LAST = SAMPLE_WIDTH'(SAMPLE_LIMIT - 1);
    localparam logic [3:0]              S_LAST     = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]              S_MID      = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [N_W-1:0]          N_LAST     = N_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd5;
`endif

    logic                    sync1_q;
    logic                    rx_s_q;
    logic [2:0]              state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] presc_q, presc_d;
    logic [3:0]              s_q, s_d;
    logic [N_W-1:0]          n_q, n_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    tick;
`ifdef UART_RX_PARITY_EN
    logic                    par_q, par_d;
    logic                    perr_q, perr_d;
`endif

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Restarting the prescaler aligns tick phase to the start edge.
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                    presc_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        n_d = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        b_d = {rx_s_q, b_q[DATA_WIDTH-1:1]};
                        s_d = '0;
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        par_d   = rx_s_q;
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        if (rx_s_q) begin
                            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{b_q, par_q}) begin
                                perr_d = 1'b1;
                            end else begin
                                data_d  = b_q;
                                valid_d = 1'b1;
                            end
`else
                            data_d  = b_q;
                            valid_d = 1'b1;
`endif
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            presc_q <= '0;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            presc_q <= presc_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with a shortened sample prescaler (64 clocks per bit).
// Define UART_RX_PARITY_EN to also cover the parity variant.
module tb_uart_receiver;

    localparam int LIMIT = 4;
    localparam int BIT   = LIMIT * 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    int         np = 0;
`endif

    int total = 0;
    int bad   = 0;
    int nv    = 0;
    int nf    = 0;
    int nboth = 0;
    logic [7:0] got[$];

    uart_receiver #(
        .DATA_WIDTH  (8),
        .SAMPLE_WIDTH(9),
        .SAMPLE_LIMIT(LIMIT),
        .OVERSAMPLE  (16)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .busy        (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (rx_valid) begin
                nv = nv + 1;
                got.push_back(rx_data);
            end
            if (frame_error) nf = nf + 1;
            if (rx_valid && frame_error) nboth = nboth + 1;
`ifdef UART_RX_PARITY_EN
            if (parity_error) np = np + 1;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_v;
        int         exp_f;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vec[8];

    initial begin
        int v0, f0, q0;
        logic [7:0] hi[5];

        vec[0] = '{8'h48, 1'b1, 1, 0, 8'h48};
        vec[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vec[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vec[3] = '{8'h55, 1'b0, 0, 1, 8'hFF};
        vec[4] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vec[5] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vec[6] = '{8'h80, 1'b1, 1, 0, 8'h80};
        vec[7] = '{8'h3C, 1'b0, 0, 1, 8'h80};
        hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h21; hi[3] = 8'h0D; hi[4] = 8'h0A;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset rx_data", 32'(rx_data), 32'h0);
        check("reset rx_valid", 32'(rx_valid), 32'h0);
        check("reset frame_error", 32'(frame_error), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            v0 = nv;
            f0 = nf;
            send_frame(vec[i].d, vec[i].stop, ^vec[i].d);
            rx = 1'b1;
            repeat (2 * BIT) @(negedge clk);
            check($sformatf("vec%0d valid count", i), 32'(nv - v0), 32'(vec[i].exp_v));
            check($sformatf("vec%0d ferr count", i), 32'(nf - f0), 32'(vec[i].exp_f));
            check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vec[i].exp_data));
            check($sformatf("vec%0d busy idle", i), 32'(busy), 32'h0);
        end

        // Start glitch shorter than half a bit is rejected.
        v0 = nv;
        f0 = nf;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch busy during", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch busy after", 32'(busy), 32'h0);
        check("glitch valid count", 32'(nv - v0), 32'h0);
        check("glitch ferr count", 32'(nf - f0), 32'h0);

        // Bad stop bit followed by a held-low line.
        v0 = nv;
        f0 = nf;
        send_frame(8'h55, 1'b0, ^8'h55);
        repeat (20 * BIT) @(negedge clk);
        check("break ferr count", 32'(nf - f0), 32'h1);
        check("break valid count", 32'(nv - v0), 32'h0);
        check("break busy held", 32'(busy), 32'h1);
        check("break rx_data kept", 32'(rx_data), 32'h80);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("break busy released", 32'(busy), 32'h0);
        repeat (BIT) @(negedge clk);

        // Back-to-back frames with no idle gap.
        v0 = nv;
        f0 = nf;
        q0 = got.size();
        for (int i = 0; i < 5; i++) send_frame(hi[i], 1'b1, ^hi[i]);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("b2b valid count", 32'(nv - v0), 32'd5);
        check("b2b ferr count", 32'(nf - f0), 32'h0);
        for (int i = 0; i < 5; i++) begin
            if (q0 + i < got.size())
                check($sformatf("b2b byte%0d", i), 32'(got[q0 + i]), 32'(hi[i]));
            else
                check($sformatf("b2b byte%0d missing", i), 32'h1, 32'h0);
        end

        // Reset in the middle of bit 4 of 0xC3.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(vec[0].d[i] ^ vec[0].d[i] ^ 8'hC3 >> i);
        rx = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset rx_data", 32'(rx_data), 32'h0);
        check("midreset busy", 32'(busy), 32'h0);
        check("midreset rx_valid", 32'(rx_valid), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        v0 = nv;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("post-reset valid count", 32'(nv - v0), 32'h1);
        check("post-reset rx_data", 32'(rx_data), 32'hA5);

`ifdef UART_RX_PARITY_EN
        begin
            int p0;
            v0 = nv;
            p0 = np;
            send_frame(8'h07, 1'b1, 1'b0);
            rx = 1'b1;
            repeat (2 * BIT) @(negedge clk);
            check("par bad perr count", 32'(np - p0), 32'h1);
            check("par bad valid count", 32'(nv - v0), 32'h0);
            check("par bad rx_data kept", 32'(rx_data), 32'hA5);
            v0 = nv;
            p0 = np;
            send_frame(8'h07, 1'b1, 1'b1);
            rx = 1'b1;
            repeat (2 * BIT) @(negedge clk);
            check("par good perr count", 32'(np - p0), 32'h0);
            check("par good valid count", 32'(nv - v0), 32'h1);
            check("par good rx_data", 32'(rx_data), 32'h07);
        end
`endif

        check("valid and ferr overlap", 32'(nboth), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
